commit_flush_ctrl: RTL and testbench

//  Sequences pipeline recovery after ROB commit. Watches the oldest committing ROB entry (commit slot 0).
//  On branch mispredict, exception, interrupt, ertn, idle, or a refetch-class flush (priv/ibar/icacop), it:
//  - raises a one-cycle global flush and a redirect PC;
//  - holds the commit port through a drain window.
//  It also implements the idle-wait state. Sits between the ROB commit output, the CSR unit and the frontend.

---
 rtl/commit_flush_ctrl_pkg.sv | 29 ++
 rtl/commit_flush_ctrl_if.sv | 30 +++
 rtl/commit_flush_ctrl_cause_enc.sv | 52 +++++
 rtl/commit_flush_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_commit_flush_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_flush_ctrl_pkg.sv
// Shared types for the commit-time flush controller: flush causes, controller
// states, the interrupt ecode and a small cause classification helper.
package commit_flush_ctrl_pkg;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_INT     = 3'd1,
        CAUSE_EXCP    = 3'd2,
        CAUSE_ERTN    = 3'd3,
        CAUSE_IDLE    = 3'd4,
        CAUSE_REFETCH = 3'd5,
        CAUSE_BR      = 3'd6
    } flush_cause_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_IDLE_WAIT = 2'd3
    } cmt_flush_state_e;

    localparam logic [5:0] ECODE_INT = 6'h00;

    // Causes that make the CSR unit latch era/ecode and vector to eentry.
    function automatic logic cause_takes_excp(flush_cause_e c);
        return (c == CAUSE_INT) || (c == CAUSE_EXCP);
    endfunction

endpackage

// File: rtl/commit_flush_ctrl_if.sv
// ROB commit slot-0 bundle: the ROB (master) presents the oldest entry and its
// flags; the flush controller (slave) answers with kill and block.
interface commit_flush_ctrl_if #(
    parameter int PC_W    = 32,
    parameter int ECODE_W = 6
);
    logic               cmt_valid;
    logic [PC_W-1:0]    cmt_pc;
    logic               cmt_br_redirect;
    logic [PC_W-1:0]    cmt_br_target;
    logic               cmt_excp_valid;
    logic [ECODE_W-1:0] cmt_excp_ecode;
    logic               cmt_ertn;
    logic               cmt_idle;
    logic               cmt_refetch;
    logic               cmt_kill;
    logic               cmt_block;

    modport master (
        output cmt_valid, cmt_pc, cmt_br_redirect, cmt_br_target,
               cmt_excp_valid, cmt_excp_ecode, cmt_ertn, cmt_idle, cmt_refetch,
        input  cmt_kill, cmt_block
    );

    modport slave (
        input  cmt_valid, cmt_pc, cmt_br_redirect, cmt_br_target,
               cmt_excp_valid, cmt_excp_ecode, cmt_ertn, cmt_idle, cmt_refetch,
        output cmt_kill, cmt_block
    );
endinterface

// File: rtl/commit_flush_ctrl_cause_enc.sv
// Priority encoder from slot-0 flags to a flush cause and redirect target.
// Order: INT > EXCP > ERTN > IDLE > REFETCH > BR. pc+4 wraps at 2^PC_W.
module flush_cause_enc
    import commit_flush_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            int_i,
    input  logic            excp_i,
    input  logic            ertn_i,
    input  logic            idle_i,
    input  logic            refetch_i,
    input  logic            br_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic [PC_W-1:0] eentry_i,
    input  logic [PC_W-1:0] era_i,
    output flush_cause_e    cause_o,
    output logic [PC_W-1:0] target_o
);
    logic [PC_W-1:0] pc_next_s;

    assign pc_next_s = pc_i + PC_W'(32'd4);

    // Pick the highest-priority cause and its redirect target.
    always_comb begin
        cause_o  = CAUSE_NONE;
        target_o = '0;
        if (int_i) begin
            cause_o  = CAUSE_INT;
            target_o = eentry_i;
        end else if (excp_i) begin
            cause_o  = CAUSE_EXCP;
            target_o = eentry_i;
        end else if (ertn_i) begin
            cause_o  = CAUSE_ERTN;
            target_o = era_i;
        end else if (idle_i) begin
            cause_o  = CAUSE_IDLE;
            target_o = pc_next_s;
        end else if (refetch_i) begin
            cause_o  = CAUSE_REFETCH;
            target_o = pc_next_s;
        end else if (br_i) begin
            cause_o  = CAUSE_BR;
            target_o = br_target_i;
        end else begin
            cause_o  = CAUSE_NONE;
            target_o = '0;
        end
    end
endmodule

// File: rtl/commit_flush_ctrl.sv
// Commit-time flush controller: watches ROB slot 0, raises a one-cycle flush
// and redirect, blocks commit through a drain window, and holds the idle-wait
// state until an interrupt arrives.
// Optional feature macro: CMT_FLUSH_PERF_EN (saturating per-cause flush counters).
module commit_flush_ctrl
    import commit_flush_ctrl_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int ECODE_W      = 6,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    commit_flush_ctrl_if.slave  cmt,
    input  logic                intr_pending_i,
    input  logic [PC_W-1:0]     csr_eentry_i,
    input  logic [PC_W-1:0]     csr_era_i,
    output logic                flush_o,
    output logic                redirect_valid_o,
    output logic [PC_W-1:0]     redirect_pc_o,
    output logic                excp_cmt_o,
    output logic [ECODE_W-1:0]  excp_ecode_o,
    output logic [PC_W-1:0]     excp_era_o,
    output logic                ertn_cmt_o,
    output logic                idle_o
`ifdef CMT_FLUSH_PERF_EN
    ,
    output logic [31:0]         perf_br_o,
    output logic [31:0]         perf_excp_o,
    output logic [31:0]         perf_int_o
`endif
);
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    cmt_flush_state_e   state_q;
    flush_cause_e       cause_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cmt_block_q;
    logic               flush_q;
    logic [PC_W-1:0]    redirect_pc_q;
    logic               excp_cmt_q;
    logic [ECODE_W-1:0] ecode_q;
    logic [PC_W-1:0]    era_q;
    logic               ertn_cmt_q;
    logic               idle_q;
    logic [PC_W-1:0]    idle_ret_q;

    logic               int_fire_s;
    logic               event_s;
    flush_cause_e       cause_s;
    logic [PC_W-1:0]    target_s;

    // Interrupts only take the head while running with a valid entry.
    assign int_fire_s = (state_q == ST_RUN) & cmt.cmt_valid & intr_pending_i;

    flush_cause_enc #(.PC_W(PC_W)) u_enc (
        .int_i       (int_fire_s),
        .excp_i      (cmt.cmt_excp_valid),
        .ertn_i      (cmt.cmt_ertn),
        .idle_i      (cmt.cmt_idle),
        .refetch_i   (cmt.cmt_refetch),
        .br_i        (cmt.cmt_br_redirect),
        .pc_i        (cmt.cmt_pc),
        .br_target_i (cmt.cmt_br_target),
        .eentry_i    (csr_eentry_i),
        .era_i       (csr_era_i),
        .cause_o     (cause_s),
        .target_o    (target_s)
    );

    assign event_s = (state_q == ST_RUN) & cmt.cmt_valid & ~cmt_block_q &
                     (cause_s != CAUSE_NONE);

    assign cmt.cmt_kill  = int_fire_s | (state_q != ST_RUN);
    assign cmt.cmt_block = cmt_block_q;

    assign flush_o          = flush_q;
    assign redirect_valid_o = flush_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign excp_cmt_o       = excp_cmt_q;
    assign excp_ecode_o     = ecode_q;
    assign excp_era_o       = era_q;
    assign ertn_cmt_o       = ertn_cmt_q;
    assign idle_o           = idle_q;

    // Flush sequencer: state, drain count and registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            cause_q       <= CAUSE_NONE;
            cnt_q         <= '0;
            cmt_block_q   <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            excp_cmt_q    <= 1'b0;
            ecode_q       <= '0;
            era_q         <= '0;
            ertn_cmt_q    <= 1'b0;
            idle_q        <= 1'b0;
            idle_ret_q    <= '0;
        end else begin
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            excp_cmt_q    <= 1'b0;
            ecode_q       <= '0;
            era_q         <= '0;
            ertn_cmt_q    <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (event_s) begin
                        state_q       <= ST_FLUSH;
                        cause_q       <= cause_s;
                        cmt_block_q   <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= target_s;
                        excp_cmt_q    <= cause_takes_excp(cause_s);
                        ertn_cmt_q    <= (cause_s == CAUSE_ERTN);
                        era_q         <= cause_takes_excp(cause_s) ? cmt.cmt_pc : '0;
                        idle_ret_q    <= cmt.cmt_pc + PC_W'(32'd4);
                        if (cause_s == CAUSE_EXCP) begin
                            ecode_q <= cmt.cmt_excp_ecode;
                        end else begin
                            ecode_q <= ECODE_W'(ECODE_INT);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cause_q == CAUSE_IDLE) begin
                        state_q <= ST_IDLE_WAIT;
                        idle_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_RUN;
                        cmt_block_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_IDLE_WAIT: begin
                    if (intr_pending_i) begin
                        state_q       <= ST_FLUSH;
                        cause_q       <= CAUSE_INT;
                        idle_q        <= 1'b0;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= csr_eentry_i;
                        excp_cmt_q    <= 1'b1;
                        ecode_q       <= ECODE_W'(ECODE_INT);
                        era_q         <= idle_ret_q;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    cmt_block_q <= 1'b0;
                    idle_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef CMT_FLUSH_PERF_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_excp_q;
    logic [31:0] perf_int_q;

    // Saturating per-cause flush counters, bumped in the FLUSH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q   <= 32'd0;
            perf_excp_q <= 32'd0;
            perf_int_q  <= 32'd0;
        end else if (state_q == ST_FLUSH) begin
            if ((cause_q == CAUSE_BR) && (perf_br_q != 32'hFFFF_FFFF)) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if ((cause_q == CAUSE_EXCP) && (perf_excp_q != 32'hFFFF_FFFF)) begin
                perf_excp_q <= perf_excp_q + 32'd1;
            end
            if ((cause_q == CAUSE_INT) && (perf_int_q != 32'hFFFF_FFFF)) begin
                perf_int_q <= perf_int_q + 32'd1;
            end
        end
    end

    assign perf_br_o   = perf_br_q;
    assign perf_excp_o = perf_excp_q;
    assign perf_int_o  = perf_int_q;
`endif

endmodule

// File: tb/tb_commit_flush_ctrl.sv
// Scoreboard bench for commit_flush_ctrl: the driver predicts each flush from
// the cause-priority rules and queues it; a negedge monitor pops and compares.
module tb_commit_flush_ctrl;
    import commit_flush_ctrl_pkg::*;

    localparam int PC_W    = 32;
    localparam int ECODE_W = 6;
    localparam int DRAIN   = 2;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        excp;
        logic        ertn;
        logic [5:0]  ecode;
        logic [31:0] era;
    } flush_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        intr_pending;
    logic [31:0] eentry, era_csr;
    logic        flush, rv, excp_cmt, ertn_cmt, idle;
    logic [31:0] rpc, era_o;
    logic [5:0]  ecode_o;
`ifdef CMT_FLUSH_PERF_EN
    logic [31:0] perf_br, perf_excp, perf_int;
`endif

    commit_flush_ctrl_if #(.PC_W(PC_W), .ECODE_W(ECODE_W)) cif ();

    commit_flush_ctrl #(.PC_W(PC_W), .ECODE_W(ECODE_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmt              (cif.slave),
        .intr_pending_i   (intr_pending),
        .csr_eentry_i     (eentry),
        .csr_era_i        (era_csr),
        .flush_o          (flush),
        .redirect_valid_o (rv),
        .redirect_pc_o    (rpc),
        .excp_cmt_o       (excp_cmt),
        .excp_ecode_o     (ecode_o),
        .excp_era_o       (era_o),
        .ertn_cmt_o       (ertn_cmt),
        .idle_o           (idle)
`ifdef CMT_FLUSH_PERF_EN
        ,
        .perf_br_o        (perf_br),
        .perf_excp_o      (perf_excp),
        .perf_int_o       (perf_int)
`endif
    );

    always #5 clk = ~clk;

    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    flush_t sb_q[$];

    // Abstract model: remaining blocked cycles, and whether the core sleeps.
    int          busy_left = 0;
    bit          in_idle = 1'b0;
    logic [31:0] idle_era = 32'd0;
    bit          exp_block = 1'b0, exp_kill = 1'b0, exp_idle = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of slot-0 stimulus and predict the controller response.
    task automatic drive(input bit v, input logic [31:0] pc, input bit br, input logic [31:0] tgt,
                         input bit ex, input logic [5:0] ec, input bit er, input bit id,
                         input bit rf, input bit it);
        flush_t r;
        bit     ev, blk, free;
        cif.cmt_valid       = v;
        cif.cmt_pc          = pc;
        cif.cmt_br_redirect = br;
        cif.cmt_br_target   = tgt;
        cif.cmt_excp_valid  = ex;
        cif.cmt_excp_ecode  = ec;
        cif.cmt_ertn        = er;
        cif.cmt_idle        = id;
        cif.cmt_refetch     = rf;
        intr_pending        = it;
        blk  = (busy_left > 0) || in_idle;
        free = !blk && v;
        exp_block = blk;
        exp_idle  = in_idle && (busy_left == 0);
        exp_kill  = blk || (v && it);
        ev = 1'b1;
        r.cyc = cyc + 1; r.excp = 1'b0; r.ertn = 1'b0; r.ecode = 6'h00; r.era = 32'd0; r.pc = 32'd0;
        if (free && it) begin
            r.pc = eentry; r.excp = 1'b1; r.era = pc;
        end else if (free && ex) begin
            r.pc = eentry; r.excp = 1'b1; r.ecode = ec; r.era = pc;
        end else if (free && er) begin
            r.pc = era_csr; r.ertn = 1'b1;
        end else if (free && (id || rf)) begin
            r.pc = pc + 32'd4;
        end else if (free && br) begin
            r.pc = tgt;
        end else if (exp_idle && it) begin
            r.pc = eentry; r.excp = 1'b1; r.era = idle_era;
        end else begin
            ev = 1'b0;
        end
        if (busy_left > 0) busy_left--;
        if (ev) begin
            sb_q.push_back(r);
            if (free && !it && !ex && !er && id) begin
                busy_left = 1; in_idle = 1'b1; idle_era = pc + 32'd4;
            end else begin
                busy_left = 1 + DRAIN; in_idle = 1'b0;
            end
        end
        mon_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic nop(input int n, input bit it);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, it);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_flush"}, flush, 1'b0);
        chk({tag, "_redir_valid"}, rv, 1'b0);
        chk({tag, "_redir_pc"}, rpc, 32'd0);
        chk({tag, "_excp_cmt"}, excp_cmt, 1'b0);
        chk({tag, "_ecode"}, ecode_o, 6'h00);
        chk({tag, "_era"}, era_o, 32'd0);
        chk({tag, "_ertn"}, ertn_cmt, 1'b0);
        chk({tag, "_idle"}, idle, 1'b0);
        chk({tag, "_block"}, cif.cmt_block, 1'b0);
        chk({tag, "_kill"}, cif.cmt_kill, 1'b0);
    endtask

    // Monitor: per-cycle block/kill/idle, and pop-and-compare on every flush.
    always @(negedge clk) begin
        flush_t r;
        if (mon_en && rst_n) begin
            chk("cmt_block", cif.cmt_block, exp_block);
            chk("cmt_kill", cif.cmt_kill, exp_kill);
            chk("idle", idle, exp_idle);
            if (flush || rv) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_flush", {rv, flush}, 2'b00);
                end else begin
                    r = sb_q.pop_front();
                    chk("flush_cycle", cyc, r.cyc);
                    chk("flush", flush, 1'b1);
                    chk("redirect_valid", rv, 1'b1);
                    chk("redirect_pc", rpc, r.pc);
                    chk("excp_cmt", excp_cmt, r.excp);
                    chk("ertn_cmt", ertn_cmt, r.ertn);
                    if (r.excp) begin
                        chk("excp_ecode", ecode_o, r.ecode);
                        chk("excp_era", era_o, r.era);
                    end
                end
            end else begin
                chk("no_excp_pulse", {excp_cmt, ertn_cmt}, 2'b00);
                if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                    r = sb_q.pop_front();
                    chk("missing_flush", 1'b0, 1'b1);
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc_v;
        nop_init();
        eentry = 32'h1C008000; era_csr = 32'h1C000500;
        #12;
        chk_zero_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // T1 branch mispredict
        drive(1'b1, 32'h1C000000, 1'b1, 32'h1C000100, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(4, 1'b0);
        // T2 exception beats branch
        drive(1'b1, 32'h1C000040, 1'b1, 32'h1C000100, 1'b1, 6'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(4, 1'b0);
        // T3 interrupt kills head
        drive(1'b1, 32'h1C000200, 1'b1, 32'h1C000100, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(4, 1'b0);
        // T4 idle, sleep 10 cycles, then wake on interrupt
        drive(1'b1, 32'h1C000300, 1'b0, 32'd0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        nop(11, 1'b0);
        nop(1, 1'b1);
        nop(4, 1'b0);
        // T5 ertn, then refetch at the top of the address space
        drive(1'b1, 32'h1C000400, 1'b0, 32'd0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        nop(4, 1'b0);
        drive(1'b1, 32'hFFFFFFFC, 1'b0, 32'd0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        nop(4, 1'b0);
        // Interrupt with no valid head does nothing
        nop(3, 1'b1);
        // T6 reset during drain
        drive(1'b1, 32'h1C000600, 1'b1, 32'h1C000700, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(1, 1'b0);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("mid_reset");
        busy_left = 0; in_idle = 1'b0;
        chk("reset_sb_empty", sb_q.size(), 0);
        sb_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 32'h1C000800, 1'b1, 32'h1C000900, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(4, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) eentry = $urandom() & 32'hFFFFFFFC;
            if ($urandom_range(0, 9) == 0) era_csr = $urandom() & 32'hFFFFFFFC;
            rpc_v = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
            drive($urandom_range(0, 99) < 55, rpc_v,
                  $urandom_range(0, 99) < 15, $urandom() & 32'hFFFFFFFC,
                  $urandom_range(0, 99) < 10, 6'($urandom_range(1, 63)),
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8);
        end
        nop(8, 1'b1);
        nop(6, 1'b0);
        chk("final_sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic nop_init();
        cif.cmt_valid = 1'b0; cif.cmt_pc = 32'd0; cif.cmt_br_redirect = 1'b0;
        cif.cmt_br_target = 32'd0; cif.cmt_excp_valid = 1'b0; cif.cmt_excp_ecode = 6'h00;
        cif.cmt_ertn = 1'b0; cif.cmt_idle = 1'b0; cif.cmt_refetch = 1'b0;
        intr_pending = 1'b0;
    endtask

endmodule
